// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the FP divide path.
// FP_DIV_RNE_EN selects round-to-nearest-even; without it the quotient is truncated.
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int EXPI_W = 10;
  localparam int QBITS  = 26;
  localparam int BIAS   = 127;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ITER,
    ROUND,
    DONE
  } state_t;

  function automatic logic [31:0] make_inf(input logic sign);
    return {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
  endfunction

  function automatic logic [31:0] make_zero(input logic sign);
    return {sign, {(EXP_W + FRAC_W){1'b0}}};
  endfunction

  function automatic logic round_inc(input logic lsb, input logic guard, input logic sticky);
`ifdef FP_DIV_RNE_EN
    return guard & (sticky | lsb);
`else
    return 1'b0;
`endif
  endfunction

endpackage

// File: rtl/fp32_classify.sv
// Splits a binary32 word into fields and classifies it; subnormals count as zero.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0]       word,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [MANT_W-1:0] mant,
  output logic              is_zero,
  output logic              is_inf,
  output logic              is_nan
);

  logic frac_nz;

  assign sign    = word[31];
  assign exp     = word[30:23];
  assign frac_nz = |word[FRAC_W-1:0];
  assign mant    = {(exp != '0), word[FRAC_W-1:0]};
  assign is_zero = (exp == '0);
  assign is_inf  = (exp == '1) && !frac_nz;
  assign is_nan  = (exp == '1) && frac_nz;

endmodule

// File: rtl/fp32_seq_divider.sv
// Multi-cycle binary32 divider: restoring radix-2 mantissa loop, 26 quotient bits.
// Define FP_DIV_RNE_EN for round-to-nearest-even; default build truncates.
module fp32_seq_divider
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_invalid,
  output logic        flag_divzero,
  output logic        flag_ovf,
  output logic        flag_unf
);

  state_t state_reg, state_next;
  logic [31:0] a_reg, a_next, b_reg, b_next, result_reg, result_next;
  logic sign_reg, sign_next, special_reg, special_next;
  logic signed [EXPI_W-1:0] exp_reg, exp_next;
  logic [MANT_W:0] rem_reg, rem_next;
  logic [MANT_W-1:0] div_reg, div_next;
  logic [QBITS-1:0] q_reg, q_next;
  logic [4:0] cnt_reg, cnt_next;
  logic inv_reg, inv_next, dz_reg, dz_next, ovf_reg, ovf_next, unf_reg, unf_next;

  logic [31:0]       op_word [2];
  logic              op_sign [2];
  logic [EXP_W-1:0]  op_exp  [2];
  logic [MANT_W-1:0] op_mant [2];
  logic              op_zero [2];
  logic              op_inf  [2];
  logic              op_nan  [2];

  assign op_word[0] = a_reg;
  assign op_word[1] = b_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cls
    fp32_classify u_cls (
      .word    (op_word[gi]),
      .sign    (op_sign[gi]),
      .exp     (op_exp[gi]),
      .mant    (op_mant[gi]),
      .is_zero (op_zero[gi]),
      .is_inf  (op_inf[gi]),
      .is_nan  (op_nan[gi])
    );
  end

  // Restoring step: a negative trial keeps the old remainder.
  logic [MANT_W+1:0] trial;
  logic [MANT_W:0]   rem_sel;
  assign trial   = {1'b0, rem_reg} - {2'b00, div_reg};
  assign rem_sel = trial[MANT_W+1] ? rem_reg : trial[MANT_W:0];

  logic [MANT_W-1:0] nrm_mant;
  logic nrm_guard, nrm_sticky;
  logic signed [EXPI_W-1:0] nrm_exp, fin_exp;
  logic [MANT_W:0] rnd_sum;
  logic [FRAC_W-1:0] fin_frac;

  always_comb begin
    if (q_reg[QBITS-1]) begin
      nrm_mant   = q_reg[QBITS-1:2];
      nrm_guard  = q_reg[1];
      nrm_sticky = q_reg[0] | (|rem_reg);
      nrm_exp    = exp_reg;
    end else begin
      nrm_mant   = q_reg[QBITS-2:1];
      nrm_guard  = q_reg[0];
      nrm_sticky = |rem_reg;
      nrm_exp    = exp_reg - 10'sd1;
    end
    rnd_sum = {1'b0, nrm_mant} + {{MANT_W{1'b0}}, round_inc(nrm_mant[0], nrm_guard, nrm_sticky)};
    if (rnd_sum[MANT_W]) begin
      fin_frac = rnd_sum[MANT_W-1:1];
      fin_exp  = nrm_exp + 10'sd1;
    end else begin
      fin_frac = rnd_sum[FRAC_W-1:0];
      fin_exp  = nrm_exp;
    end
  end

  assign in_ready     = (state_reg == IDLE);
  assign out_valid    = (state_reg == DONE);
  assign result       = result_reg;
  assign flag_invalid = inv_reg;
  assign flag_divzero = dz_reg;
  assign flag_ovf     = ovf_reg;
  assign flag_unf     = unf_reg;

  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    result_next  = result_reg;
    sign_next    = sign_reg;
    special_next = special_reg;
    exp_next     = exp_reg;
    rem_next     = rem_reg;
    div_next     = div_reg;
    q_next       = q_reg;
    cnt_next     = cnt_reg;
    inv_next     = inv_reg;
    dz_next      = dz_reg;
    ovf_next     = ovf_reg;
    unf_next     = unf_reg;
    case (state_reg)
      IDLE: if (in_valid) begin
        a_next     = a;
        b_next     = b;
        state_next = UNPACK;
      end
      UNPACK: begin
        sign_next    = op_sign[0] ^ op_sign[1];
        special_next = 1'b1;
        inv_next     = 1'b0;
        dz_next      = 1'b0;
        ovf_next     = 1'b0;
        unf_next     = 1'b0;
        // Specials still pass through ROUND so their latency is a fixed 2 cycles.
        state_next   = ROUND;
        if (op_nan[0] || op_nan[1] || (op_zero[0] && op_zero[1]) || (op_inf[0] && op_inf[1])) begin
          result_next = QNAN;
          inv_next    = 1'b1;
        end else if (op_zero[1] && !op_inf[0]) begin
          result_next = make_inf(op_sign[0] ^ op_sign[1]);
          dz_next     = 1'b1;
        end else if (op_inf[0]) begin
          result_next = make_inf(op_sign[0] ^ op_sign[1]);
        end else if (op_inf[1] || op_zero[0]) begin
          result_next = make_zero(op_sign[0] ^ op_sign[1]);
        end else begin
          special_next = 1'b0;
          exp_next     = $signed({2'b00, op_exp[0]}) - $signed({2'b00, op_exp[1]}) + $signed(10'(BIAS));
          rem_next     = {1'b0, op_mant[0]};
          div_next     = op_mant[1];
          cnt_next     = 5'(QBITS);
          state_next   = ITER;
        end
      end
      ITER: begin
        q_next   = {q_reg[QBITS-2:0], ~trial[MANT_W+1]};
        rem_next = rem_sel << 1;
        cnt_next = cnt_reg - 5'd1;
        if (cnt_reg == 5'd1) state_next = ROUND;
      end
      ROUND: begin
        state_next = DONE;
        if (!special_reg) begin
          inv_next = 1'b0;
          dz_next  = 1'b0;
          ovf_next = 1'b0;
          unf_next = 1'b0;
          if (fin_exp >= 10'sd255) begin
            result_next = make_inf(sign_reg);
            ovf_next    = 1'b1;
          end else if (fin_exp <= 10'sd0) begin
            result_next = make_zero(sign_reg);
            unf_next    = 1'b1;
          end else begin
            result_next = {sign_reg, fin_exp[EXP_W-1:0], fin_frac};
          end
        end
      end
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      result_reg  <= '0;
      sign_reg    <= 1'b0;
      special_reg <= 1'b0;
      exp_reg     <= '0;
      rem_reg     <= '0;
      div_reg     <= '0;
      q_reg       <= '0;
      cnt_reg     <= '0;
      inv_reg     <= 1'b0;
      dz_reg      <= 1'b0;
      ovf_reg     <= 1'b0;
      unf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      result_reg  <= result_next;
      sign_reg    <= sign_next;
      special_reg <= special_next;
      exp_reg     <= exp_next;
      rem_reg     <= rem_next;
      div_reg     <= div_next;
      q_reg       <= q_next;
      cnt_reg     <= cnt_next;
      inv_reg     <= inv_next;
      dz_reg      <= dz_next;
      ovf_reg     <= ovf_next;
      unf_reg     <= unf_next;
    end
  end

endmodule

// File: tb/tb_fp32_seq_divider.sv
// Directed bench for fp32_seq_divider against an exact-remainder quotient model.
// Expectations follow FP_DIV_RNE_EN the same way the design does.
module tb_fp32_seq_divider;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic        flag_invalid, flag_divzero, flag_ovf, flag_unf;

  fp32_seq_divider dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .flag_invalid (flag_invalid),
    .flag_divzero (flag_divzero),
    .flag_ovf     (flag_ovf),
    .flag_unf     (flag_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;   // {invalid, divzero, ovf, unf}
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef FP_DIV_RNE_EN
  localparam logic [31:0] THIRD    = 32'h3EAAAAAB;
  localparam logic [31:0] NEAR_ONE = 32'h3F800001;
`else
  localparam logic [31:0] THIRD    = 32'h3EAAAAAA;
  localparam logic [31:0] NEAR_ONE = 32'h3F800000;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Quotient normalised to [2^23, 2^24) by integer division; rounding decided from the exact remainder.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t   m;
    logic   s, zx, zy, ix, iy, nx, ny;
    int     ex, ey, e;
    longint ma, mb, q, r;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    zx = (ex == 0);
    zy = (ey == 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    m.lat = 2;
    m.flg = 4'b0000;
    if (nx || ny || (zx && zy) || (ix && iy)) begin
      m.res = 32'h7FC00000;
      m.flg = 4'b1000;
    end else if (zy && !ix) begin
      m.res = {s, 8'hFF, 23'h0};
      m.flg = 4'b0100;
    end else if (ix) begin
      m.res = {s, 8'hFF, 23'h0};
    end else if (iy || zx) begin
      m.res = {s, 31'h0};
    end else begin
      m.lat = 28;
      ma = longint'({1'b1, x[22:0]});
      mb = longint'({1'b1, y[22:0]});
      e  = ex - ey + 127;
      if (ma >= mb) begin
        q = (ma << 23) / mb;
        r = (ma << 23) % mb;
      end else begin
        q = (ma << 24) / mb;
        r = (ma << 24) % mb;
        e = e - 1;
      end
`ifdef FP_DIV_RNE_EN
      if ((2 * r > mb) || ((2 * r == mb) && q[0])) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
`endif
      if (e >= 255) begin
        m.res = {s, 8'hFF, 23'h0};
        m.flg = 4'b0010;
      end else if (e <= 0) begin
        m.res = {s, 31'h0};
        m.flg = 4'b0001;
      end else begin
        m.res = {s, e[7:0], q[22:0]};
      end
    end
    return m;
  endfunction

  // Every cycle the output is valid it must match the pending expectation and block new input.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_out_valid: got result %h with no division pending", result);
      end else begin
        check("result", result, exp_q[0].res);
        check("flags", {28'd0, flag_invalid, flag_divzero, flag_ovf, flag_unf}, {28'd0, exp_q[0].flg});
        check("in_ready_busy", {31'd0, in_ready}, 32'd0);
      end
    end
  end

  task automatic run(input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] lit_res, input logic [3:0] lit_flg, input int hold);
    exp_t m;
    int   w, lat;
    m = model(x, y);
    check("model_res", m.res, lit_res);
    check("model_flags", {28'd0, m.flg}, {28'd0, lit_flg});
    @(negedge clk);
    a = x;
    b = y;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready got 0, expected 1");
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(m);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL result_timeout: out_valid got 0 after %0d cycles, expected 1", lat);
      exp_q.delete();
      return;
    end
    check("latency", lat, m.lat);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_xfer", {31'd0, in_ready}, 32'd1);
    check("out_valid_after_xfer", {31'd0, out_valid}, 32'd0);
    void'(exp_q.pop_front());
    $display("div %h / %h -> expected %h flags %b, latency %0d, hold %0d", x, y, m.res, m.flg, lat, hold);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {28'd0, flag_invalid, flag_divzero, flag_ovf, flag_unf}, 32'd0);
    rst = 1'b0;

    run(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 0);
    run(32'h3F800000, 32'h40400000, THIRD,        4'b0000, 0);
    run(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 0);
    run(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 0);
    run(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b0010, 0);
    run(32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 0);
    run(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 5);
    run(32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 0);
    run(32'h3F800000, 32'h3F7FFFFF, NEAR_ONE,     4'b0000, 0);
    run(32'h3F800000, 32'h3F800001, 32'h3F7FFFFE, 4'b0000, 0);
    run(32'h7F800000, 32'h00000000, 32'h7F800000, 4'b0000, 0);
    run(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 0);
    run(32'h40000000, 32'hFF800000, 32'h80000000, 4'b0000, 0);
    run(32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 0);
    run(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 0);
    run(32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 0);
    run(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 0);
    run(32'h3F800000, 32'h00000001, 32'h7F800000, 4'b0100, 2);
    run(32'h80800000, 32'h40000000, 32'h80000000, 4'b0001, 0);
    run(32'h00800000, 32'h7F7FFFFF, 32'h00000000, 4'b0001, 0);

    // Abort a division mid-iteration with reset, then confirm the block recovers.
    @(negedge clk);
    a = 32'h40C00000;
    b = 32'h40000000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_result", result, 32'd0);
    rst = 1'b0;
    $display("abort: reset asserted during ITER, out_valid %0b in_ready %0b", out_valid, in_ready);
    run(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
